data_memory_print: RTL and testbench
====================================

DATA_MEMORY_PRINT -- requirements
Module: data_memory_print

Interface
REQ-001 Parameter ADDR_BASE, default 32'h7FF00000; lowest valid word address.
REQ-002 Parameter DEPTH_WORDS, default 1024, power of two; number of 32-bit words.
REQ-003 Parameter MAX_CHARS, default 256; print length limit, excluding the NUL.
REQ-004 Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sig_mem_write  in  1  write strobe.
- sig_mem_read  in  1  read strobe.
- byte_en  in  4  write lane enables; bit3 = data[31:24].
- addr  in  32  word address.
- write_data  in  32  write data.
- read_data  out  32  registered read data.
- read_valid  out  1  read_data valid, one-cycle pulse.
- addr_fault  out  1  access out of range, one-cycle pulse.
- print_start  in  1  start string print.
- print_addr  in  32  word address of first string word.
- print_busy  out  1  engine not IDLE.
- char_valid  out  1  char_data valid.
- char_ready  in  1  consumer accepts char.
- char_data  out  8  character byte.
- print_done  out  1  string finished, one-cycle pulse.
- print_fault  out  1  print aborted, one-cycle pulse.

Function
REQ-005 Valid range SHALL be ADDR_BASE <= addr <= ADDR_BASE+DEPTH_WORDS-1; index = addr-ADDR_BASE; comparison unsigned, no 32-bit wrap.
REQ-006 Write SHALL update only lanes with byte_en set, at the edge where sig_mem_write=1 and addr is in range.
REQ-007 Read SHALL have 1-cycle latency: read_data/read_valid appear the cycle after sig_mem_read=1.
REQ-008 Same-address read and write in one cycle SHALL return the pre-write word.
REQ-009 Out-of-range read or write SHALL leave memory unchanged, give read_data=0 (for reads), read_valid=0 and addr_fault=1 the following cycle.
REQ-010 Simultaneous sig_mem_read and sig_mem_write SHALL perform both.
REQ-011 Engine FSM states: IDLE, FETCH, EMIT, DONE, FAULT.
REQ-012 IDLE -> FETCH on print_start; latches print_addr as pointer, char count = 0. print_start outside IDLE SHALL be ignored.
REQ-013 FETCH: pointer out of range -> FAULT; else latch the word via an internal read port that does not conflict with the CPU port, byte index = 3, -> EMIT next cycle.
REQ-014 EMIT: char_data = current byte, MSB first; char_valid=1 except when byte is 8'h00.
REQ-015 NUL byte -> DONE without asserting char_valid.
REQ-016 char_data/char_valid SHALL hold stable until char_valid&char_ready; on handshake the count increments and the byte index decrements; after byte 0 -> FETCH with pointer+1.
REQ-017 Accepting character MAX_CHARS without a NUL SHALL -> FAULT.
REQ-018 DONE and FAULT SHALL each last one cycle, pulse print_done or print_fault respectively, then -> IDLE.
REQ-019 CPU writes during printing SHALL NOT alter the latched word; they take effect at the next FETCH.
REQ-020 print_busy = 1 in every state except IDLE.

Reset
REQ-021 rst_n low SHALL force IDLE and clear read_data, read_valid, addr_fault, char_valid, char_data, print_done, print_fault and print_busy to 0, regardless of clk.
REQ-022 Memory contents SHALL NOT be reset; a reset mid-print aborts it with no print_done.

Structure
REQ-023 The FSM state enum and the default ADDR_BASE SHALL live in the shared CPU package.
REQ-024 The print engine SHALL be sub-module print_string_engine, fed by the internal read port.

Verification
REQ-025 Write 32'hdeadbeef to 7FFFFFFE, read it -> read_data=deadbeef, read_valid next cycle.
REQ-026 byte_en=4'b0011, data 32'h12345678 over deadbeef -> read back dead5678.
REQ-027 Read 7FEFFFFF -> addr_fault=1, read_data=0; write there -> memory unchanged.
REQ-028 Store 68656c6c, 6f20776f, 726c6400 at 7FFFFFF0..F2, print_start at 7FFFFFF0, char_ready=1 -> chars "hello world" (11), then print_done.
REQ-029 Same string with char_ready toggling every other cycle -> char_data held while not ready, same 11 chars.
REQ-030 Print at 7FFFFFFF with no NUL -> 4 chars, then print_fault on the out-of-range FETCH; rst_n low mid-EMIT -> IDLE, no print_done.

Source files
------------

// File: rtl/data_memory_print_pkg.sv
// Shared CPU package: print engine states, default memory base and address range helper.
package data_memory_print_pkg;

    localparam logic [31:0] DMP_ADDR_BASE = 32'h7FF00000;

    typedef enum logic [2:0] {
        PS_IDLE,
        PS_FETCH,
        PS_EMIT,
        PS_DONE,
        PS_FAULT
    } print_state_e;

    // 33-bit difference: addresses below base wrap to a huge value and fail the compare.
    function automatic logic addr_in_range(input logic [31:0] a,
                                           input logic [31:0] base,
                                           input logic [31:0] depth);
        return (({1'b0, a} - {1'b0, base}) < {1'b0, depth});
    endfunction

endpackage

// File: rtl/data_memory_print_print_string_engine.sv
// Walks a NUL-terminated string in memory, MSB byte first, handing chars out over a valid/ready pair.
module print_string_engine
    import data_memory_print_pkg::*;
#(
    parameter int MAX_CHARS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] addr_i,
    output logic [31:0] rd_addr_o,
    input  logic        rd_in_range_i,
    input  logic [31:0] rd_data_i,
    output logic        busy_o,
    output logic        char_valid_o,
    input  logic        char_ready_i,
    output logic [7:0]  char_data_o,
    output logic        done_o,
    output logic        fault_o
);
    localparam int CW = $clog2(MAX_CHARS + 1);

    print_state_e   state_q, state_d;
    logic [31:0]    ptr_q, ptr_d;
    logic [31:0]    word_q, word_d;
    logic [1:0]     idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     cur_byte;

    assign cur_byte  = word_q[{idx_q, 3'b000} +: 8];
    assign rd_addr_o = ptr_q;
    assign busy_o    = (state_q != PS_IDLE);
    assign done_o    = (state_q == PS_DONE);
    assign fault_o   = (state_q == PS_FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PS_IDLE;
            ptr_q   <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        word_d       = word_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        char_valid_o = 1'b0;
        char_data_o  = 8'h00;
        case (state_q)
            PS_IDLE: begin
                if (start_i) begin
                    ptr_d   = addr_i;
                    cnt_d   = '0;
                    state_d = PS_FETCH;
                end
            end
            PS_FETCH: begin
                if (!rd_in_range_i) begin
                    state_d = PS_FAULT;
                end else begin
                    word_d  = rd_data_i;
                    idx_d   = 2'd3;
                    state_d = PS_EMIT;
                end
            end
            PS_EMIT: begin
                char_data_o = cur_byte;
                if (cur_byte == 8'h00) begin
                    state_d = PS_DONE;
                end else begin
                    char_valid_o = 1'b1;
                    if (char_ready_i) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CW'(MAX_CHARS - 1)) begin
                            state_d = PS_FAULT;
                        end else if (idx_q == 2'd0) begin
                            ptr_d   = ptr_q + 32'd1;
                            state_d = PS_FETCH;
                        end else begin
                            idx_d = idx_q - 2'd1;
                        end
                    end
                end
            end
            PS_DONE:  state_d = PS_IDLE;
            PS_FAULT: state_d = PS_IDLE;
            default:  state_d = PS_IDLE;
        endcase
    end

endmodule

// File: rtl/data_memory_print.sv
// Word-addressed data memory with byte-lane writes, a registered CPU read port and a string print engine.
module data_memory_print
    import data_memory_print_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = DMP_ADDR_BASE,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          MAX_CHARS   = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sig_mem_write,
    input  logic        sig_mem_read,
    input  logic [3:0]  byte_en,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic        addr_fault,
    input  logic        print_start,
    input  logic [31:0] print_addr,
    output logic        print_busy,
    output logic        char_valid,
    input  logic        char_ready,
    output logic [7:0]  char_data,
    output logic        print_done,
    output logic        print_fault
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic          cpu_ok;
    logic [AW-1:0] cpu_idx;
    logic [31:0]   read_data_q;
    logic          read_valid_q, addr_fault_q;

    logic [31:0]   eng_addr;
    logic          eng_ok;
    logic [AW-1:0] eng_idx;
    logic [31:0]   eng_rdata;

    assign cpu_ok  = addr_in_range(addr, ADDR_BASE, 32'(DEPTH_WORDS));
    assign cpu_idx = AW'(addr - ADDR_BASE);

    // Engine port is a separate asynchronous read so it never steals a cycle from the CPU.
    assign eng_ok    = addr_in_range(eng_addr, ADDR_BASE, 32'(DEPTH_WORDS));
    assign eng_idx   = AW'(eng_addr - ADDR_BASE);
    assign eng_rdata = mem_q[eng_idx];

    always_ff @(posedge clk) begin
        if (sig_mem_write && cpu_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem_q[cpu_idx][8*b +: 8] <= write_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            addr_fault_q <= 1'b0;
        end else begin
            read_data_q  <= (sig_mem_read && cpu_ok) ? mem_q[cpu_idx] : 32'h0;
            read_valid_q <= sig_mem_read && cpu_ok;
            addr_fault_q <= (sig_mem_read || sig_mem_write) && !cpu_ok;
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign addr_fault = addr_fault_q;

    print_string_engine #(.MAX_CHARS(MAX_CHARS)) u_eng (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (print_start),
        .addr_i       (print_addr),
        .rd_addr_o    (eng_addr),
        .rd_in_range_i(eng_ok),
        .rd_data_i    (eng_rdata),
        .busy_o       (print_busy),
        .char_valid_o (char_valid),
        .char_ready_i (char_ready),
        .char_data_o  (char_data),
        .done_o       (print_done),
        .fault_o      (print_fault)
    );

endmodule

// File: tb/tb_data_memory_print.sv
// Scoreboard bench: CPU port checks plus print runs whose expected chars are queued up front.
module tb_data_memory_print;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig_mem_write = 1'b0, sig_mem_read = 1'b0;
    logic [3:0]  byte_en = 4'h0;
    logic [31:0] addr = '0, write_data = '0;
    logic [31:0] read_data;
    logic        read_valid, addr_fault;
    logic        print_start = 1'b0;
    logic [31:0] print_addr = '0;
    logic        print_busy, char_valid, print_done, print_fault;
    logic        char_ready = 1'b0;
    logic [7:0]  char_data;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    data_memory_print #(.ADDR_BASE(32'h7FFFFC00), .DEPTH_WORDS(1024), .MAX_CHARS(256)) dut (
        .clk(clk), .rst_n(rst_n), .sig_mem_write(sig_mem_write), .sig_mem_read(sig_mem_read),
        .byte_en(byte_en), .addr(addr), .write_data(write_data), .read_data(read_data),
        .read_valid(read_valid), .addr_fault(addr_fault), .print_start(print_start),
        .print_addr(print_addr), .print_busy(print_busy), .char_valid(char_valid),
        .char_ready(char_ready), .char_data(char_data), .print_done(print_done),
        .print_fault(print_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cpu_op(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        sig_mem_write = wr; sig_mem_read = rd; addr = a; write_data = d; byte_en = be;
        @(negedge clk);
        sig_mem_write = 1'b0; sig_mem_read = 1'b0; byte_en = 4'h0;
    endtask

    task automatic cpu_read(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                            input logic exp_v, input logic exp_f);
        cpu_op(1'b0, 1'b1, a, 32'h0, 4'h0);
        chk({tag, "_data"}, read_data, exp_d);
        chk({tag, "_valid"}, {31'b0, read_valid}, {31'b0, exp_v});
        chk({tag, "_fault"}, {31'b0, addr_fault}, {31'b0, exp_f});
    endtask

    task automatic run_print(input string tag, input logic [31:0] a, input string s,
                             input bit toggle, input bit exp_fault);
        bit held_v = 1'b0;
        logic [7:0] held = 8'h00;
        bit saw_done = 1'b0, saw_fault = 1'b0, finished = 1'b0;
        logic [7:0] e;
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        char_ready = toggle ? 1'b0 : 1'b1;
        @(negedge clk);
        print_start = 1'b1; print_addr = a;
        @(negedge clk);
        print_start = 1'b0;
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (toggle) char_ready = ~char_ready;
            if (char_valid) begin
                if (held_v) chk({tag, "_hold"}, {24'b0, char_data}, {24'b0, held});
                if (char_ready) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    chk({tag, "_char"}, {24'b0, char_data}, {24'b0, e});
                    held_v = 1'b0;
                end else begin
                    held_v = 1'b1; held = char_data;
                end
            end
            if (print_done)  begin saw_done = 1'b1;  finished = 1'b1; end
            if (print_fault) begin saw_fault = 1'b1; finished = 1'b1; end
        end
        chk({tag, "_finished"}, {31'b0, finished}, 32'd1);
        chk({tag, "_left"}, exp_q.size(), 32'd0);
        chk({tag, "_done"}, {31'b0, saw_done}, {31'b0, !exp_fault});
        chk({tag, "_faultp"}, {31'b0, saw_fault}, {31'b0, exp_fault});
        exp_q.delete();
        char_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, {31'b0, print_busy}, 32'd0);
    endtask

    initial begin
        string a256;
        bit seen;
        #2;
        chk("rst_rdata", read_data, 32'h0);
        chk("rst_rvalid", {31'b0, read_valid}, 32'd0);
        chk("rst_afault", {31'b0, addr_fault}, 32'd0);
        chk("rst_busy", {31'b0, print_busy}, 32'd0);
        chk("rst_cvalid", {31'b0, char_valid}, 32'd0);
        chk("rst_done_fault", {30'b0, print_done, print_fault}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        cpu_op(1'b1, 1'b0, 32'h7FFFFFFE, 32'hdeadbeef, 4'hF);
        chk("wr_rvalid", {31'b0, read_valid}, 32'd0);
        cpu_read("rd_full", 32'h7FFFFFFE, 32'hdeadbeef, 1'b1, 1'b0);
        cpu_op(1'b1, 1'b0, 32'h7FFFFFFE, 32'h12345678, 4'b0011);
        cpu_read("rd_lanes", 32'h7FFFFFFE, 32'hdead5678, 1'b1, 1'b0);
        cpu_op(1'b1, 1'b1, 32'h7FFFFFFE, 32'h11111111, 4'hF);
        chk("rw_old", read_data, 32'hdead5678);
        cpu_read("rw_new", 32'h7FFFFFFE, 32'h11111111, 1'b1, 1'b0);

        cpu_op(1'b1, 1'b0, 32'h7FFFFFFF, 32'h41424344, 4'hF);
        cpu_read("oor_lo", 32'h7FEFFFFF, 32'h0, 1'b0, 1'b1);
        cpu_read("oor_hi", 32'h80000000, 32'h0, 1'b0, 1'b1);
        cpu_op(1'b1, 1'b0, 32'h7FEFFFFF, 32'hcafef00d, 4'hF);
        chk("oor_wr_fault", {31'b0, addr_fault}, 32'd1);
        cpu_read("oor_wr_keep", 32'h7FFFFFFF, 32'h41424344, 1'b1, 1'b0);
        cpu_read("top_word", 32'h7FFFFFFF, 32'h41424344, 1'b1, 1'b0);

        cpu_op(1'b1, 1'b0, 32'h7FFFFFF0, 32'h68656c6c, 4'hF);
        cpu_op(1'b1, 1'b0, 32'h7FFFFFF1, 32'h6f20776f, 4'hF);
        cpu_op(1'b1, 1'b0, 32'h7FFFFFF2, 32'h726c6400, 4'hF);
        run_print("hello", 32'h7FFFFFF0, "hello world", 1'b0, 1'b0);
        run_print("hello_tog", 32'h7FFFFFF0, "hello world", 1'b1, 1'b0);
        run_print("nonul", 32'h7FFFFFFF, "ABCD", 1'b0, 1'b1);

        a256 = "";
        for (int i = 0; i < 64; i++) cpu_op(1'b1, 1'b0, 32'h7FFFFC00 + i, 32'h41414141, 4'hF);
        for (int i = 0; i < 256; i++) a256 = {a256, "A"};
        run_print("maxc", 32'h7FFFFC00, a256, 1'b0, 1'b1);

        // Reset while a char is waiting for ready.
        char_ready = 1'b0;
        @(negedge clk);
        print_start = 1'b1; print_addr = 32'h7FFFFFF0;
        @(negedge clk);
        print_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = char_valid;
        end
        chk("mid_emit_valid", {31'b0, seen}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, print_busy}, 32'd0);
        chk("mid_rst_cvalid", {31'b0, char_valid}, 32'd0);
        chk("mid_rst_cdata", {24'b0, char_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        char_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (print_done || char_valid) seen = 1'b1;
        end
        chk("mid_rst_nodone", {31'b0, seen}, 32'd0);
        cpu_read("mem_kept", 32'h7FFFFFF0, 32'h68656c6c, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
